imem_fetch_arbiter: RTL and testbench

Shares one instruction SRAM between NUM_REQ local command processors. Each processor's fetch port (address plus a level read-enable, answered by a one-cycle valid pulse with data) connects to this block. It grants one fetch per cycle in round-robin order, tracks each in-flight read through a READ_LAT-deep tag pipeline, and routes the returned word back to the requester that issued it. It sits between the per-tile command processors and the shared instruction memory macro.

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/imem_fetch_arbiter_rr_arbiter.sv | 33 +++
 rtl/imem_fetch_arbiter.sv | 144 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared defaults and helpers for the instruction-memory fetch arbiter.
// Optional statistics are enabled with the IMEM_ARB_STATS_EN macro.
package imem_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 20;
    localparam int DEF_DATA_W   = 128;
    localparam int DEF_READ_LAT = 1;
    localparam int STAT_W       = 32;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: lowest offset from i_ptr wins.
// Reusable for any N-wide request vector.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_c;

    // Walk offsets from the far end so the nearest requester is written last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_c = (int'(i_ptr) + k) % N;
            if (i_req[w_c]) begin
                o_gnt      = '0;
                o_gnt[w_c] = 1'b1;
                o_idx      = IW'(w_c);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one instruction SRAM between NUM_REQ fetch ports, one grant per cycle.
// Define IMEM_ARB_STATS_EN to add grant/conflict counters and their ports.
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]        i_req_re,
    output logic [DATA_W-1:0]         o_req_data,
    output logic [NUM_REQ-1:0]        o_req_valid,
    output logic [ADDR_W-1:0]         o_sram_addr,
    output logic                      o_sram_re,
    input  logic [DATA_W-1:0]         i_sram_rdata
`ifdef IMEM_ARB_STATS_EN
    ,
    input  logic                      i_stat_clr,
    output logic [NUM_REQ*32-1:0]     o_stat_grant_cnt,
    output logic [31:0]               o_stat_conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_REQ-1:0] r_outstanding;
    logic [IDX_W-1:0]   r_rr_ptr;
    tag_t               r_tag [READ_LAT];
    logic [NUM_REQ-1:0] r_req_valid;
    logic [DATA_W-1:0]  r_req_data;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic [ADDR_W-1:0]  w_sram_addr;
    tag_t               w_tag_last;
    logic [NUM_REQ-1:0] w_ret_oh;

    assign w_eligible = i_req_re & ~r_outstanding;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .i_req (w_eligible),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    always_comb begin
        w_sram_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_sram_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign o_sram_re   = w_gnt_any;
    assign o_sram_addr = w_sram_addr;

    assign w_tag_last = r_tag[READ_LAT-1];

    always_comb begin
        w_ret_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ret_oh[i] = w_tag_last.vld && (w_tag_last.idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < READ_LAT; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= '{vld: w_gnt_any, idx: w_gnt_idx};
            for (int s = 1; s < READ_LAT; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    // A requester stays blocked through its valid cycle so a held re cannot double-issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~r_req_valid) | w_gnt;
            if (w_gnt_any) r_rr_ptr <= IDX_W'(wrap_inc(int'(w_gnt_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_valid <= '0;
            r_req_data  <= '0;
        end else begin
            r_req_valid <= w_ret_oh;
            if (w_tag_last.vld) r_req_data <= i_sram_rdata;
        end
    end

    assign o_req_valid = r_req_valid;
    assign o_req_data  = r_req_data;

`ifdef IMEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];
    logic [STAT_W-1:0] r_conflict_cnt;
    logic              w_conflict;

    assign w_conflict = ($countones(w_eligible) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_conflict_cnt <= '0;
        end else if (i_stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i]) r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
            end
            if (w_conflict) r_conflict_cnt <= sat_inc(r_conflict_cnt);
        end
    end

    always_comb begin
        o_stat_grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) o_stat_grant_cnt[i*32 +: 32] = r_grant_cnt[i];
    end

    assign o_stat_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: two instances (READ_LAT 1 and 2) checked against a
// per-requester due-cycle model; stats compared when IMEM_ARB_STATS_EN is defined.
module tb_imem_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 128;

    logic clk;
    logic rst_n;

    logic [N-1:0]    re   [2];
    logic [N*AW-1:0] ad   [2];
    logic [N-1:0]    vld  [2];
    logic [DW-1:0]   dat  [2];
    logic            sre  [2];
    logic [AW-1:0]   sad  [2];
    logic [DW-1:0]   rdat [2];
`ifdef IMEM_ARB_STATS_EN
    logic            clr  [2];
    logic [N*32-1:0] sgc  [2];
    logic [31:0]     scc  [2];
`endif

    int total = 0;
    int bad   = 0;

    int               cyc;
    int               lat      [2];
    int               due      [2][N];
    logic [AW-1:0]    cap      [2][N];
    int               ptr      [2];
    logic [DW-1:0]    last_dat [2];
    longint           gcnt     [2][N];
    longint           ccnt     [2];

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {12'h0, a};
        return {x * 32'h9E3779B1, ~x, x ^ 32'hA5A55A5A, x + 32'h01234567};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: data for an address presented in cycle t appears in cycle t+READ_LAT.
    logic [AW-1:0] sa0_q, sa1_a, sa1_b;
    always @(posedge clk) begin
        sa0_q <= sad[0];
        sa1_a <= sad[1];
        sa1_b <= sa1_a;
    end
    assign rdat[0] = memf(sa0_q);
    assign rdat[1] = memf(sa1_b);

    imem_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut0 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req_addr          (ad[0]),
        .i_req_re            (re[0]),
        .o_req_data          (dat[0]),
        .o_req_valid         (vld[0]),
        .o_sram_addr         (sad[0]),
        .o_sram_re           (sre[0]),
        .i_sram_rdata        (rdat[0])
`ifdef IMEM_ARB_STATS_EN
        ,
        .i_stat_clr          (clr[0]),
        .o_stat_grant_cnt    (sgc[0]),
        .o_stat_conflict_cnt (scc[0])
`endif
    );

    imem_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_dut1 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req_addr          (ad[1]),
        .i_req_re            (re[1]),
        .o_req_data          (dat[1]),
        .o_req_valid         (vld[1]),
        .o_sram_addr         (sad[1]),
        .o_sram_re           (sre[1]),
        .i_sram_rdata        (rdat[1])
`ifdef IMEM_ARB_STATS_EN
        ,
        .i_stat_clr          (clr[1]),
        .o_stat_grant_cnt    (sgc[1]),
        .o_stat_conflict_cnt (scc[1])
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr[d]      = 0;
            last_dat[d] = '0;
            ccnt[d]     = 0;
            for (int i = 0; i < N; i++) begin
                due[d][i]  = -1;
                cap[d][i]  = '0;
                gcnt[d][i] = 0;
            end
        end
    endtask

    // Compare one instance for the current cycle, then advance its model past the edge.
    task automatic model_step(input int d);
        logic [N-1:0]  exp_v;
        logic [DW-1:0] exp_d;
        int            g;
        int            n_elig;
        logic [AW-1:0] g_addr;
        exp_v  = '0;
        exp_d  = last_dat[d];
        for (int i = 0; i < N; i++) begin
            if (due[d][i] == cyc) begin
                exp_v[i] = 1'b1;
                exp_d    = memf(cap[d][i]);
            end
        end
        chk($sformatf("valid%0d@%0d", d, cyc), vld[d], exp_v);
        chk($sformatf("data%0d@%0d", d, cyc), dat[d], exp_d);
        g      = -1;
        n_elig = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr[d] + k) % N;
            if (re[d][i] && due[d][i] < cyc) begin
                n_elig++;
                if (g < 0) g = i;
            end
        end
        g_addr = (g >= 0) ? ad[d][g*AW +: AW] : '0;
        chk($sformatf("sram_re%0d@%0d", d, cyc), sre[d], (g >= 0));
        chk($sformatf("sram_addr%0d@%0d", d, cyc), sad[d], g_addr);
`ifdef IMEM_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("grant_cnt%0d[%0d]@%0d", d, i, cyc), sgc[d][i*32 +: 32], gcnt[d][i][31:0]);
        chk($sformatf("conflict_cnt%0d@%0d", d, cyc), scc[d], ccnt[d][31:0]);
        if (clr[d]) begin
            ccnt[d] = 0;
            for (int i = 0; i < N; i++) gcnt[d][i] = 0;
        end else begin
            if (n_elig > 1) ccnt[d]++;
            if (g >= 0) gcnt[d][g]++;
        end
`endif
        if (g >= 0) begin
            due[d][g] = cyc + lat[d] + 1;
            cap[d][g] = g_addr;
            ptr[d]    = (g + 1) % N;
        end
        last_dat[d] = exp_d;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        re[0] = '0;
        re[1] = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid0", vld[0], '0);
        chk("rst_valid1", vld[1], '0);
        chk("rst_data0", dat[0], '0);
        chk("rst_data1", dat[1], '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_addr(input int d, input int i, input logic [AW-1:0] a);
        ad[d][i*AW +: AW] = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        lat[0] = 1;
        lat[1] = 2;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            re[d] = '0;
            ad[d] = '0;
`ifdef IMEM_ARB_STATS_EN
            clr[d] = 1'b0;
`endif
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid0", vld[0], '0);
        chk("reset_data0", dat[0], '0);
        chk("reset_sram_re0", sre[0], 1'b0);
        rst_n = 1'b1;

        // Single requester, READ_LAT=1, address 5 held.
        set_addr(0, 0, 20'd5);
        re[0] = 4'b0001;
        #1;
        chk("s1_sram_re_t", sre[0], 1'b1);
        chk("s1_sram_addr_t", sad[0], 20'd5);
        tick();
        chk("s1_no_regrant_t1", sre[0], 1'b0);
        tick();
        chk("s1_valid_t2", vld[0], 4'b0001);
        chk("s1_data_t2", dat[0], memf(20'd5));
        chk("s1_no_regrant_t2", sre[0], 1'b0);
        tick();
        chk("s1_valid_off_t3", vld[0], 4'b0000);
        chk("s1_regrant_t3", sre[0], 1'b1);
        tick();
        re[0] = '0;
        repeat (4) tick();

        // Four requesters at once after reset, addresses 0..3; each drops re on its valid.
        do_reset();
        for (int i = 0; i < N; i++) set_addr(0, i, AW'(i));
        re[0] = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            re[0] = re[0] & ~vld[0];
            if (c == 1) chk("s2_valid_req0", vld[0], 4'b0001);
            if (c == 4) chk("s2_valid_req3", vld[0], 4'b1000);
        end
`ifdef IMEM_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk($sformatf("s2_grant_cnt[%0d]", i), sgc[0][i*32 +: 32], 32'd1);
        chk("s2_conflict_cnt", scc[0], 32'd3);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("s2_clr_grant", sgc[0], '0);
        chk("s2_clr_conflict", scc[0], '0);
`endif

        // Requesters 1 and 3 hold re continuously on the READ_LAT=2 instance.
        set_addr(1, 1, 20'h11111);
        set_addr(1, 3, 20'h33333);
        re[1] = 4'b1010;
        repeat (16) tick();
        re[1] = '0;
        repeat (5) tick();

        // Requester 2 drops re one cycle after its grant.
        set_addr(0, 2, 20'h00009);
        re[0] = 4'b0100;
        tick();
        re[0] = '0;
        tick();
        chk("s4_valid_req2", vld[0], 4'b0100);
        repeat (4) tick();

        // Reset with three reads in flight on the READ_LAT=2 instance.
        for (int i = 0; i < N; i++) set_addr(1, i, AW'($urandom));
        re[1] = 4'b1111;
        repeat (3) tick();
        do_reset();
        repeat (5) tick();
        re[1] = 4'b1111;
        #1;
        chk("s5_first_grant_addr", sad[1], ad[1][AW-1:0]);
        repeat (8) tick();
        re[1] = '0;
        repeat (4) tick();

        // Randomized traffic, addresses changing every cycle, one mid-run reset.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 15) == 0)
                    re[d] = N'($urandom);
                else
                    re[d] = (re[d] & ~vld[d]) | N'($urandom & $urandom);
                ad[d] = {$urandom, $urandom, $urandom};
`ifdef IMEM_ARB_STATS_EN
                clr[d] = ($urandom_range(0, 39) == 0);
`endif
            end
            if (c == 200) do_reset();
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            re[d] = '0;
`ifdef IMEM_ARB_STATS_EN
            clr[d] = 1'b0;
`endif
        end
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
